dtw_core_feeder: RTL and testbench

//   Drives the DTW core datapath from the other side of its stream interface.
//   - Reads the SQG_SIZE-sample query squiggle from squiggle memory and ref_len reference words from reference memory.
//   - Presents one squiggle/ref pair per cycle, cycle-exact, because the core cannot stall.
//   - Pads the reference stream once it is exhausted, then waits for core completion.
//   - Captures minval/position and reports a one-cycle done pulse. Sits between the job controller and dtw_core_datapath.

---
 rtl/dtw_core_feeder.sv | 171 +++++++++++++++++
 tb/tb_dtw_core_feeder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtw_core_feeder.sv
// -----------------------------------------------------------------------------
// dtw_core_feeder
//   Feeds the DTW core datapath one squiggle/reference pair per cycle. The core
//   cannot stall, so the feed is cycle-exact. The feeder reads the query
//   squiggle and the reference words from two synchronous-read memories. When
//   the reference is exhausted it pads with PAD_WORD, then lets the core drain.
//   Finally it captures the core's minimum and position and raises a
//   one-cycle done pulse.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   start, abort, cfg_ref_len   job control from the job controller
//   busy, done_o                job status
//   result_minval, result_pos   captured core result, held after done_o
//   sq_rd_*                     squiggle memory read port (1-cycle latency)
//   ref_rd_*                    reference memory read port (1-cycle latency)
//   core_rst, core_running      core clear / run enable
//   core_squiggle, core_rword   registered data pair to the core
//   core_ref_len                reference length latched at job start
//   core_done, core_minval,
//   core_position               core completion and result
// -----------------------------------------------------------------------------
module dtw_core_feeder #(
  parameter int               width    = 16,
  parameter int               SQG_SIZE = 250,
  parameter logic [width-1:0] PAD_WORD = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      cfg_ref_len,
  output logic             busy,
  output logic             done_o,
  output logic [width-1:0] result_minval,
  output logic [31:0]      result_pos,
  output logic             sq_rd_en,
  output logic [7:0]       sq_rd_addr,
  input  logic [width-1:0] sq_rd_data,
  output logic             ref_rd_en,
  output logic [31:0]      ref_rd_addr,
  input  logic [width-1:0] ref_rd_data,
  output logic             core_rst,
  output logic             core_running,
  output logic [width-1:0] core_squiggle,
  output logic [width-1:0] core_rword,
  output logic [31:0]      core_ref_len,
  input  logic             core_done,
  input  logic [width-1:0] core_minval,
  input  logic [31:0]      core_position
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN1,
    S_DRAIN2,
    S_DONE,
    S_ABORT   // one-cycle core clear after a cancelled job
  } state_t;

  localparam logic [7:0] SQ_LAST = 8'(SQG_SIZE - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  sq_last_addr;   // last squiggle index issued this job
  logic [31:0] ref_last_addr;  // last reference index issued this job
  logic [31:0] ref_len_q;
  logic        run_first;      // high during RUN cycle 0, where core_done is ignored
  logic        sq_pend;        // a squiggle read was issued last cycle
  logic        ref_pend;       // a reference read was issued last cycle
  logic        sq_more;
  logic        ref_more;

  // The read counters stop at their last index instead of wrapping.
  assign sq_more  = (sq_last_addr != SQ_LAST);
  assign ref_more = (ref_last_addr != (ref_len_q - 32'd1));

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave a variable unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = (cfg_ref_len == '0) ? S_DONE : S_CLEAR;
      S_CLEAR:  state_nxt = abort ? S_ABORT : S_RUN;
      S_RUN: begin
        // abort wins over a simultaneous core_done
        if (abort)                        state_nxt = S_ABORT;
        else if (core_done && !run_first) state_nxt = S_DRAIN1;
      end
      S_DRAIN1: state_nxt = abort ? S_ABORT : S_DRAIN2;
      S_DRAIN2: state_nxt = abort ? S_ABORT : S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      S_ABORT:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != S_IDLE) && (state != S_DONE);
    done_o       = (state == S_DONE);
    core_running = (state == S_RUN) || (state == S_DRAIN1) || (state == S_DRAIN2);
    // The core is held in clear for the whole of our own reset, not only at the edge.
    core_rst     = !rst_n || (state == S_CLEAR) || (state == S_ABORT);
    core_ref_len = ref_len_q;
    sq_rd_en     = 1'b0;
    sq_rd_addr   = '0;
    ref_rd_en    = 1'b0;
    ref_rd_addr  = '0;
    if (state == S_CLEAR) begin
      sq_rd_en  = 1'b1;
      ref_rd_en = 1'b1;
    end else if (state == S_RUN) begin
      sq_rd_en  = sq_more;
      ref_rd_en = ref_more;
      if (sq_more)  sq_rd_addr  = sq_last_addr + 8'd1;
      if (ref_more) ref_rd_addr = ref_last_addr + 32'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      sq_last_addr  <= '0;
      ref_last_addr <= '0;
      ref_len_q     <= '0;
      run_first     <= 1'b0;
      sq_pend       <= 1'b0;
      ref_pend      <= 1'b0;
      core_squiggle <= '0;
      core_rword    <= '0;
      result_minval <= '1;
      result_pos    <= '0;
    end else begin
      state     <= state_nxt;
      run_first <= (state == S_CLEAR);

      // Memory data arrives one cycle after the read and is registered once
      // more, so index i reaches the core in RUN cycle i+1.
      sq_pend       <= sq_rd_en;
      ref_pend      <= ref_rd_en;
      core_squiggle <= sq_pend  ? sq_rd_data  : '0;
      core_rword    <= ref_pend ? ref_rd_data : PAD_WORD;

      if (state == S_IDLE && start && cfg_ref_len != '0) ref_len_q <= cfg_ref_len;

      if (state == S_CLEAR) begin
        sq_last_addr  <= '0;
        ref_last_addr <= '0;
      end else if (state == S_RUN) begin
        if (sq_rd_en)  sq_last_addr  <= sq_rd_addr;
        if (ref_rd_en) ref_last_addr <= ref_rd_addr;
      end

      // An empty reference skips the core and reports the "no match" result.
      if (state_nxt == S_DONE) begin
        if (state == S_IDLE) begin
          result_minval <= '1;
          result_pos    <= '0;
        end else begin
          result_minval <= core_minval;
          result_pos    <= core_position;
        end
      end
    end
  end

endmodule

// File: tb/tb_dtw_core_feeder.sv
// -----------------------------------------------------------------------------
// tb_dtw_core_feeder
//   Directed bench for dtw_core_feeder with SQG_SIZE=4. Stimulus tasks push
//   per-cycle expectations (core data pair, run/clear/busy) and expected
//   done results into queues. A monitor pops and compares them 1 ns after
//   each rising edge. Memories are modelled with one-cycle read latency:
//   squiggle = {1,2,3,4}, and reference word at address a = 10+a.
// -----------------------------------------------------------------------------
module tb_dtw_core_feeder;

  localparam int          W   = 16;
  localparam int          SQG = 4;
  localparam logic [15:0] PAD = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] cfg_ref_len;
  logic        busy;
  logic        done_o;
  logic [15:0] result_minval;
  logic [31:0] result_pos;
  logic        sq_rd_en;
  logic [7:0]  sq_rd_addr;
  logic [15:0] sq_rd_data = '0;
  logic        ref_rd_en;
  logic [31:0] ref_rd_addr;
  logic [15:0] ref_rd_data = '0;
  logic        core_rst;
  logic        core_running;
  logic [15:0] core_squiggle;
  logic [15:0] core_rword;
  logic [31:0] core_ref_len;
  logic        core_done;
  logic [15:0] core_minval;
  logic [31:0] core_position;

  dtw_core_feeder #(.width(W), .SQG_SIZE(SQG), .PAD_WORD(PAD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_ref_len(cfg_ref_len),
    .busy(busy), .done_o(done_o), .result_minval(result_minval), .result_pos(result_pos),
    .sq_rd_en(sq_rd_en), .sq_rd_addr(sq_rd_addr), .sq_rd_data(sq_rd_data),
    .ref_rd_en(ref_rd_en), .ref_rd_addr(ref_rd_addr), .ref_rd_data(ref_rd_data),
    .core_rst(core_rst), .core_running(core_running), .core_squiggle(core_squiggle),
    .core_rword(core_rword), .core_ref_len(core_ref_len), .core_done(core_done),
    .core_minval(core_minval), .core_position(core_position)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] sq_mem [SQG] = '{16'd1, 16'd2, 16'd3, 16'd4};

  always @(posedge clk) begin
    if (sq_rd_en)  sq_rd_data  <= (sq_rd_addr < 8'(SQG)) ? sq_mem[sq_rd_addr[1:0]] : 16'hDEAD;
    if (ref_rd_en) ref_rd_data <= 16'(ref_rd_addr + 32'd10);
  end

  typedef struct {
    int          cyc;
    bit          chk_data;
    logic [15:0] sq;
    logic [15:0] rw;
    bit          running;
    bit          rst;
    bit          busy;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [15:0] mv;
    logic [31:0] pos;
  } done_t;

  exp_t  exp_q[$];
  done_t done_q[$];

  int checks = 0;
  int errors = 0;
  int sq_tot = 0;
  int ref_tot = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_exp(input int cy, input bit cd, input logic [15:0] sq, input logic [15:0] rw,
                          input bit run, input bit rst, input bit bsy);
    exp_t e;
    e.cyc = cy; e.chk_data = cd; e.sq = sq; e.rw = rw;
    e.running = run; e.rst = rst; e.busy = bsy;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int cy, input logic [15:0] mv, input logic [31:0] pos);
    done_t d;
    d.cyc = cy; d.mv = mv; d.pos = pos;
    done_q.push_back(d);
  endtask

  // Expected core pair for RUN cycle n (n >= 1) of a job with reference length len.
  task automatic push_run_data(input int c, input int n, input int len);
    int          idx;
    logic [15:0] sq;
    logic [15:0] rw;
    idx = n - 1;
    sq  = (idx < SQG) ? sq_mem[idx] : 16'h0000;
    rw  = (idx < len) ? 16'(10 + idx) : PAD;
    push_exp(c + 2 + n, 1'b1, sq, rw, 1'b1, 1'b0, 1'b1);
  endtask

  // Monitor: compares whatever the stimulus queued for this cycle, and any done pulse.
  initial begin
    exp_t  e;
    done_t d;
    forever begin
      @(posedge clk);
      #1;
      if (sq_rd_en)  sq_tot++;
      if (ref_rd_en) ref_tot++;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        if (e.cyc != cyc) check("exp_cycle", 32'(cyc), 32'(e.cyc));
        check("core_running", 32'(core_running), 32'(e.running));
        check("core_rst", 32'(core_rst), 32'(e.rst));
        check("busy", 32'(busy), 32'(e.busy));
        if (e.chk_data) begin
          check("core_squiggle", 32'(core_squiggle), 32'(e.sq));
          check("core_rword", 32'(core_rword), 32'(e.rw));
        end
      end
      if (done_o) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 32'(done_o), 32'd0);
        end else begin
          d = done_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(d.cyc));
          check("result_minval", 32'(result_minval), 32'(d.mv));
          check("result_pos", result_pos, d.pos);
          check("busy_in_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  // Full job. done_at is the RUN cycle where the core model raises core_done.
  // early also pulses core_done in RUN cycle 0, which must be ignored.
  // glitch pulses start in RUN cycle 3 and changes cfg_ref_len mid-run.
  task automatic run_job(input int len, input int done_at, input logic [15:0] mv,
                         input logic [31:0] pos, input bit early, input bit glitch);
    int c;
    int sq0;
    int ref0;
    int exp_ref;
    @(negedge clk);
    c = cyc; sq0 = sq_tot; ref0 = ref_tot;
    start = 1'b1; cfg_ref_len = 32'(len); core_minval = mv; core_position = pos;
    push_exp(c + 1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
    push_exp(c + 2, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
    for (int n = 1; n <= done_at + 2; n++) push_run_data(c, n, len);
    push_exp(c + done_at + 5, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    push_exp(c + done_at + 6, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    push_done(c + done_at + 5, mv, pos);
    while (cyc < c + done_at + 7) begin
      @(negedge clk);
      start       = glitch && (cyc == c + 5);
      cfg_ref_len = (glitch && cyc >= c + 5) ? 32'd99 : 32'(len);
      core_done   = (cyc == c + 2 + done_at) || (early && cyc == c + 2);
      // Change the core result after capture; the held result must not follow.
      if (cyc >= c + done_at + 5) core_minval = 16'hBEEF;
    end
    start = 1'b0; core_done = 1'b0; cfg_ref_len = '0;
    exp_ref = (len < done_at + 1) ? len : done_at + 1;
    check("sq_rd_en_cycles", 32'(sq_tot - sq0), 32'(SQG));
    check("ref_rd_en_cycles", 32'(ref_tot - ref0), 32'(exp_ref));
    check("core_ref_len", core_ref_len, 32'(len));
    check("result_held", 32'(result_minval), 32'(mv));
  endtask

  initial begin : stim
    int c;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_ref_len = '0;
    core_done = 1'b0; core_minval = '0; core_position = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_minval", 32'(result_minval), 32'hFFFF);
    check("rst_pos", result_pos, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_running", 32'(core_running), 32'd0);
    check("rst_sq_rd_en", 32'(sq_rd_en), 32'd0);
    check("rst_ref_len", core_ref_len, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_core_rst", 32'(core_rst), 32'd0);

    // Streaming alignment, padding and done timing
    run_job(8, 20, 16'h0123, 32'd7, 1'b0, 1'b0);
    // Short reference, ignored RUN-0 core_done, start/len change mid-run
    run_job(2, 6, 16'h0042, 32'd3, 1'b1, 1'b1);

    // Zero-length reference: immediate done, core untouched
    @(negedge clk);
    c = cyc; start = 1'b1; cfg_ref_len = '0;
    push_exp(c + 1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    push_exp(c + 2, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    push_exp(c + 3, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    push_done(c + 1, 16'hFFFF, 32'd0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("len0_core_ref_len", core_ref_len, 32'd2);

    // Abort in RUN cycle 5, together with core_done
    @(negedge clk);
    c = cyc; start = 1'b1; cfg_ref_len = 32'd8; core_minval = 16'h0999; core_position = 32'd44;
    push_exp(c + 1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
    push_exp(c + 2, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
    for (int n = 1; n <= 5; n++) push_run_data(c, n, 8);
    push_exp(c + 8, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
    push_exp(c + 9, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    push_exp(c + 10, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    while (cyc < c + 11) begin
      @(negedge clk);
      abort     = (cyc == c + 7);
      core_done = (cyc == c + 7);
    end
    check("abort_minval_kept", 32'(result_minval), 32'hFFFF);
    check("abort_pos_kept", result_pos, 32'd0);

    // New job after abort
    run_job(5, 4, 16'h0555, 32'd12, 1'b0, 1'b0);

    // Reset during DRAIN
    @(negedge clk);
    c = cyc; start = 1'b1; cfg_ref_len = 32'd8; core_minval = 16'h0777; core_position = 32'd9;
    push_exp(c + 1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
    push_exp(c + 2, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    while (cyc < c + 4) @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    rst_n = 1'b0;
    #1;
    check("drain_running", 32'(core_running), 32'd1);
    check("drain_rst_comb", 32'(core_rst), 32'd1);
    @(negedge clk);
    check("rst2_done", 32'(done_o), 32'd0);
    check("rst2_minval", 32'(result_minval), 32'hFFFF);
    check("rst2_pos", result_pos, 32'd0);
    check("rst2_core_rst", 32'(core_rst), 32'd1);
    check("rst2_busy", 32'(busy), 32'd0);
    check("rst2_running", 32'(core_running), 32'd0);
    @(negedge clk);
    check("rst2_core_rst_held", 32'(core_rst), 32'd1);
    check("rst2_done_held", 32'(done_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst2_released_core_rst", 32'(core_rst), 32'd0);
    @(negedge clk);
    @(negedge clk);

    check("exp_q_left", 32'(exp_q.size()), 32'd0);
    check("done_q_left", 32'(done_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
